// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths, interface FSM states, ALU opcodes.
package uart_pkg;

   localparam int unsigned DATA_BITS   = 8;
   localparam int unsigned OP_BITS_DEF = 6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_B  = 3'd1,
      ST_WAIT_OP = 3'd2,
      ST_EXEC    = 3'd3,
      ST_SEND    = 3'd4,
      ST_WAIT_TX = 3'd5
   } intf_state_e;

   localparam logic [5:0] OP_SRL = 6'h02;
   localparam logic [5:0] OP_SRA = 6'h03;
   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_NOR = 6'h27;

   // Counter width able to hold 0..cycles, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      int unsigned w;
      w = $clog2(longint'(cycles) + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/intf_timer.sv
// Inter-byte timeout counter: synchronous clear, count enable, terminal-count flag.
module intf_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tc
);
   import uart_pkg::*;

   localparam int unsigned   CW     = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TC_VAL = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear wins over enable, otherwise hold.
   always_comb begin
      cnt_d = cnt_q;
      if (i_clear) begin
         cnt_d = '0;
      end else if (i_enable) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A zero limit disables the timeout entirely.
   assign o_tc = (TIMEOUT_CYCLES != 0) && i_enable && (cnt_q == TC_VAL);

endmodule

// File: rtl/uart_alu_intf.sv
// Frames three received bytes (A, B, opcode) into an ALU operation and sends
// the result byte back through the transmitter.
module uart_alu_intf #(
   parameter int unsigned Bits           = uart_pkg::DATA_BITS,
   parameter int unsigned OP_BITS        = uart_pkg::OP_BITS_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic               i_Clock,
   input  logic               i_reset,
   input  logic               i_rx_done,
   input  logic [Bits-1:0]    i_rx_data,
   input  logic               i_tx_active,
   input  logic               i_tx_done,
   input  logic [Bits-1:0]    i_alu_result,
   output logic [Bits-1:0]    o_alu_a,
   output logic [Bits-1:0]    o_alu_b,
   output logic [OP_BITS-1:0] o_alu_op,
   output logic               o_tx_start,
   output logic [Bits-1:0]    o_tx_data,
   output logic               o_busy,
   output logic               o_timeout,
   output logic               o_overrun
);
   import uart_pkg::*;

   intf_state_e        state_q, state_d;
   logic [Bits-1:0]    alu_a_q, alu_a_d;
   logic [Bits-1:0]    alu_b_q, alu_b_d;
   logic [OP_BITS-1:0] alu_op_q, alu_op_d;
   logic [Bits-1:0]    tx_data_q, tx_data_d;
   logic               timeout_q, timeout_d;
   logic               overrun_q, overrun_d;
   logic               tx_start;
   logic               tmr_clear, tmr_en, tmr_tc;

   intf_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk    (i_Clock),
      .i_rst_n  (i_reset),
      .i_clear  (tmr_clear),
      .i_enable (tmr_en),
      .o_tc     (tmr_tc)
   );

   // Next-state and datapath loads; a byte arriving on the terminal-count
   // cycle takes priority over the timeout.
   always_comb begin
      state_d   = state_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      tx_data_d = tx_data_q;
      timeout_d = 1'b0;
      overrun_d = 1'b0;
      tx_start  = 1'b0;
      tmr_clear = 1'b0;
      tmr_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_rx_done) begin
               alu_a_d   = i_rx_data;
               tmr_clear = 1'b1;
               state_d   = ST_WAIT_B;
            end
         end
         ST_WAIT_B: begin
            tmr_en = 1'b1;
            if (i_rx_done) begin
               alu_b_d   = i_rx_data;
               tmr_clear = 1'b1;
               state_d   = ST_WAIT_OP;
            end else if (tmr_tc) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_WAIT_OP: begin
            tmr_en = 1'b1;
            if (i_rx_done) begin
               alu_op_d  = i_rx_data[OP_BITS-1:0];
               tmr_clear = 1'b1;
               state_d   = ST_EXEC;
            end else if (tmr_tc) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_EXEC: begin
            overrun_d = i_rx_done;
            tx_data_d = i_alu_result;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            overrun_d = i_rx_done;
            if (!i_tx_active) begin
               tx_start = 1'b1;
               state_d  = ST_WAIT_TX;
            end
         end
         ST_WAIT_TX: begin
            overrun_d = i_rx_done;
            if (i_tx_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_Clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= ST_IDLE;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= '0;
         tx_data_q <= '0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         tx_data_q <= tx_data_d;
         timeout_q <= timeout_d;
         overrun_q <= overrun_d;
      end
   end

   // The start pulse is decoded from SEND so it appears two clocks after the
   // opcode edge; reset forces IDLE and therefore clears it at once.
   assign o_tx_start = tx_start;
   assign o_busy     = (state_q != ST_IDLE);
   assign o_alu_a    = alu_a_q;
   assign o_alu_b    = alu_b_q;
   assign o_alu_op   = alu_op_q;
   assign o_tx_data  = tx_data_q;
   assign o_timeout  = timeout_q;
   assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_intf.sv
// Directed bench for uart_alu_intf with a small behavioural ALU on i_alu_result.
module tb_uart_alu_intf;
   import uart_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       tx_active;
   logic       tx_done;
   logic [7:0] alu_result;
   logic [7:0] alu_a, alu_b, tx_data;
   logic [5:0] alu_op;
   logic       tx_start, busy, timeout, overrun;

   int errors = 0;
   int checks = 0;
   string phase = "init";

   always #5 clk = ~clk;

   uart_alu_intf #(
      .Bits(8),
      .OP_BITS(6),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .i_Clock      (clk),
      .i_reset      (rst_n),
      .i_rx_done    (rx_done),
      .i_rx_data    (rx_data),
      .i_tx_active  (tx_active),
      .i_tx_done    (tx_done),
      .i_alu_result (alu_result),
      .o_alu_a      (alu_a),
      .o_alu_b      (alu_b),
      .o_alu_op     (alu_op),
      .o_tx_start   (tx_start),
      .o_tx_data    (tx_data),
      .o_busy       (busy),
      .o_timeout    (timeout),
      .o_overrun    (overrun)
   );

   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [5:0] op);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NOR:  return ~(a | b);
         OP_SRL:  return a >> b;
         OP_SRA:  return 8'($signed(a) >>> b);
         default: return 8'h00;
      endcase
   endfunction

   always_comb alu_result = alu_model(alu_a, alu_b, alu_op);

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op_byte;
      logic [5:0] exp_op;
      logic [7:0] exp_res;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h", phase, name, act, exp);
      end
   endtask

   task automatic chk_all_zero();
      chk("rst_alu_a", {24'd0, alu_a}, 32'h0);
      chk("rst_alu_b", {24'd0, alu_b}, 32'h0);
      chk("rst_alu_op", {26'd0, alu_op}, 32'h0);
      chk("rst_tx_start", {31'd0, tx_start}, 32'h0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      chk("rst_timeout", {31'd0, timeout}, 32'h0);
      chk("rst_overrun", {31'd0, overrun}, 32'h0);
   endtask

   // Byte strobed for one clock; returns 1 time unit after the sampling edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Entered one unit after the opcode edge (EXEC), with tx_active low.
   task automatic finish_frame(input logic [7:0] exp);
      #1;
      chk("exec_no_start", {31'd0, tx_start}, 32'h0);
      chk("exec_busy", {31'd0, busy}, 32'h1);
      cycle();
      chk("send_start", {31'd0, tx_start}, 32'h1);
      chk("send_tx_data", {24'd0, tx_data}, {24'd0, exp});
      cycle();
      chk("start_single", {31'd0, tx_start}, 32'h0);
      chk("wait_tx_busy", {31'd0, busy}, 32'h1);
      tx_done = 1'b1;
      cycle();
      tx_done = 1'b0;
      chk("done_idle", {31'd0, busy}, 32'h0);
      chk("done_hold_data", {24'd0, tx_data}, {24'd0, exp});
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op_byte,
                            input logic [5:0] exp_op, input logic [7:0] exp);
      send_byte(a);
      chk("alu_a", {24'd0, alu_a}, {24'd0, a});
      send_byte(b);
      chk("alu_b", {24'd0, alu_b}, {24'd0, b});
      send_byte(op_byte);
      chk("alu_op", {26'd0, alu_op}, {26'd0, exp_op});
      finish_frame(exp);
   endtask

   initial begin
      int cnt;

      vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
      vecs[1] = '{8'h10, 8'h30, 8'h22, 6'h22, 8'hE0};
      vecs[2] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
      vecs[3] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF};
      vecs[4] = '{8'hAA, 8'hFF, 8'h26, 6'h26, 8'h55};
      vecs[5] = '{8'h0F, 8'h30, 8'h27, 6'h27, 8'hC0};
      vecs[6] = '{8'h80, 8'h03, 8'h02, 6'h02, 8'h10};
      vecs[7] = '{8'h80, 8'h03, 8'h03, 6'h03, 8'hF0};
      vecs[8] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
      vecs[9] = '{8'h07, 8'h08, 8'hE0, 6'h20, 8'h0F};

      rst_n = 1'b0;
      rx_done = 1'b0;
      rx_data = 8'h00;
      tx_active = 1'b0;
      tx_done = 1'b0;

      phase = "reset";
      #2;
      chk_all_zero();
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();

      phase = "tx_done_idle";
      tx_done = 1'b1;
      cycle();
      tx_done = 1'b0;
      chk("idle_ignores_tx_done", {31'd0, busy}, 32'h0);

      for (int i = 0; i < 10; i++) begin
         phase = $sformatf("vec%0d", i);
         run_frame(vecs[i].a, vecs[i].b, vecs[i].op_byte, vecs[i].exp_op, vecs[i].exp_res);
      end

      // Stray tx_done while waiting for B must not disturb the frame.
      phase = "tx_done_wait_b";
      send_byte(8'h0C);
      tx_done = 1'b1;
      cycle();
      tx_done = 1'b0;
      chk("wait_b_busy", {31'd0, busy}, 32'h1);
      send_byte(8'h0A);
      send_byte(8'h24);
      finish_frame(8'h08);

      // Transmitter busy for 10 clocks after the opcode edge.
      phase = "tx_active";
      tx_active = 1'b1;
      run_frame_prefix: begin
         send_byte(8'h09);
         send_byte(8'h04);
         send_byte(8'h22);
      end
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         cnt += int'(tx_start);
         cycle();
      end
      chk("no_start_while_active", cnt, 0);
      chk("held_in_send", {31'd0, busy}, 32'h1);
      tx_active = 1'b0;
      #1;
      chk("start_after_active", {31'd0, tx_start}, 32'h1);
      cycle();
      chk("start_once", {31'd0, tx_start}, 32'h0);
      chk("delayed_data", {24'd0, tx_data}, 32'h05);

      // Byte arriving in WAIT_TX is dropped with an overrun pulse.
      phase = "overrun";
      chk("pre_overrun", {31'd0, overrun}, 32'h0);
      send_byte(8'hEE);
      #1;
      chk("overrun_pulse", {31'd0, overrun}, 32'h1);
      chk("overrun_data_kept", {24'd0, tx_data}, 32'h05);
      chk("overrun_a_kept", {24'd0, alu_a}, 32'h09);
      chk("overrun_still_busy", {31'd0, busy}, 32'h1);
      cycle();
      chk("overrun_one_cycle", {31'd0, overrun}, 32'h0);
      tx_done = 1'b1;
      cycle();
      tx_done = 1'b0;
      chk("overrun_then_idle", {31'd0, busy}, 32'h0);
      run_frame(8'h02, 8'h06, 8'h24, 6'h24, 8'h02);

      // Silence after operand A: timeout on the 16th WAIT_B clock.
      phase = "timeout";
      send_byte(8'h05);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         cycle();
         cnt += int'(timeout);
      end
      chk("no_early_timeout", cnt, 0);
      chk("busy_before_timeout", {31'd0, busy}, 32'h1);
      cycle();
      chk("timeout_pulse", {31'd0, timeout}, 32'h1);
      chk("timeout_idle", {31'd0, busy}, 32'h0);
      chk("timeout_a_kept", {24'd0, alu_a}, 32'h05);
      cycle();
      chk("timeout_one_cycle", {31'd0, timeout}, 32'h0);
      run_frame(8'h01, 8'h02, 8'h25, 6'h25, 8'h03);

      // Bytes landing exactly on the terminal-count clock are accepted.
      phase = "coincide";
      send_byte(8'h09);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         cycle();
         cnt += int'(timeout);
      end
      send_byte(8'h0A);
      #1;
      cnt += int'(timeout);
      chk("coincide_b_taken", {24'd0, alu_b}, 32'h0A);
      chk("coincide_b_busy", {31'd0, busy}, 32'h1);
      for (int i = 0; i < 15; i++) begin
         cycle();
         cnt += int'(timeout);
      end
      send_byte(8'h20);
      cnt += int'(timeout);
      chk("coincide_op_taken", {26'd0, alu_op}, 32'h20);
      finish_frame(8'h13);
      chk("coincide_no_timeout", cnt, 0);

      // Asynchronous reset in WAIT_OP.
      phase = "reset_wait_op";
      send_byte(8'h11);
      send_byte(8'h22);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero();
      cycle();
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         cnt += int'(tx_start) + int'(busy);
      end
      chk("quiet_after_reset_op", cnt, 0);

      // Asynchronous reset in SEND while the transmitter is busy.
      phase = "reset_send";
      tx_active = 1'b1;
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h25);
      cycle();
      chk("in_send_busy", {31'd0, busy}, 32'h1);
      chk("in_send_data", {24'd0, tx_data}, 32'h77);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero();
      cycle();
      rst_n = 1'b1;
      tx_active = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         cnt += int'(tx_start) + int'(busy);
         cycle();
      end
      chk("quiet_after_reset_send", cnt, 0);

      // First byte after reset is operand A.
      phase = "after_reset";
      run_frame(8'h05, 8'h03, 8'h20, 6'h20, 8'h08);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_alu_intf.md
UART_ALU_INTF -- requirements
Module: uart_alu_intf

Interface
REQ-001 The block SHALL have parameter Bits, default 8, giving the UART data byte width.
REQ-002 The block SHALL have parameter OP_BITS, default 6, giving the ALU opcode width (OP_BITS <= Bits).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, giving the inter-byte timeout in clocks; 0 disables the timeout.
REQ-004 i_Clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-low reset.
REQ-006 i_rx_done  in  1  one-cycle pulse from the receiver: a byte is on i_rx_data.
REQ-007 i_rx_data  in  Bits  received byte, valid while i_rx_done is high.
REQ-008 i_tx_active  in  1  transmitter busy.
REQ-009 i_tx_done  in  1  one-cycle pulse: transmitter finished its byte.
REQ-010 i_alu_result  in  Bits  combinational ALU result for the current o_alu_a/o_alu_b/o_alu_op.
REQ-011 o_alu_a  out  Bits  operand A register.
REQ-012 o_alu_b  out  Bits  operand B register.
REQ-013 o_alu_op  out  OP_BITS  opcode register.
REQ-014 o_tx_start  out  1  one-cycle start pulse to the transmitter.
REQ-015 o_tx_data  out  Bits  byte to transmit, held stable from o_tx_start until i_tx_done.
REQ-016 o_busy  out  1  high in every state except IDLE.
REQ-017 o_timeout  out  1  one-cycle pulse when a partial frame is abandoned.
REQ-018 o_overrun  out  1  one-cycle pulse when an i_rx_done is dropped.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
REQ-020 IDLE: on i_rx_done, load o_alu_a <= i_rx_data and go to WAIT_B.
REQ-021 WAIT_B: on i_rx_done, load o_alu_b and go to WAIT_OP.
REQ-022 WAIT_OP: on i_rx_done, load o_alu_op <= i_rx_data[OP_BITS-1:0] and go to EXEC.
REQ-023 EXEC SHALL last exactly one clock and latch o_tx_data <= i_alu_result at its closing edge, then go to SEND.
REQ-024 SEND: if i_tx_active is low, assert o_tx_start for exactly one clock and go to WAIT_TX; else stay in SEND with o_tx_start low.
REQ-025 WAIT_TX: on i_tx_done, go to IDLE; o_alu_a/b/op and o_tx_data keep their values.
REQ-026 Latency: o_tx_start SHALL rise in the second clock after the edge sampling the opcode's i_rx_done, given i_tx_active low.
REQ-027 Timeout counter SHALL clear on entry to WAIT_B and on each accepted byte, and increment each clock in WAIT_B/WAIT_OP.
REQ-028 When the counter reaches TIMEOUT_CYCLES-1 without a byte, the FSM SHALL return to IDLE and pulse o_timeout; operand registers are unchanged.
REQ-029 If i_rx_done and the timeout terminal count coincide, the byte SHALL be accepted and no timeout reported.
REQ-030 i_rx_done in EXEC, SEND or WAIT_TX SHALL be dropped and pulse o_overrun in the same following cycle; the state is unaffected.
REQ-031 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-032 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.

Reset
REQ-033 On i_reset low, the block SHALL immediately enter IDLE and clear every output and the timeout counter to 0, including mid-frame and mid-transmit.
REQ-034 After i_reset deasserts, the first i_rx_done SHALL be treated as operand A.

Structure
REQ-035 State encodings and default widths (Bits, OP_BITS) SHALL reside in the shared package uart_pkg, which is also used by the UART top.
REQ-036 The timeout counter SHALL be the sub-module intf_timer (clear, enable, terminal-count pulse).

Verification
REQ-037 Bytes 0x05, 0x03, 0x20 (ADD) with ALU model -> o_tx_data=0x08, one o_tx_start pulse 2 clocks after the 3rd i_rx_done, back to IDLE after i_tx_done.
REQ-038 i_tx_active held high 10 clocks after opcode -> o_tx_start delayed until the first clock with i_tx_active low, exactly one pulse.
REQ-039 TIMEOUT_CYCLES=16, send 0x05 then silence -> o_timeout at the 16th clock in WAIT_B, o_busy=0; next 3 bytes form a fresh frame.
REQ-040 Extra i_rx_done during WAIT_TX -> o_overrun pulse, result byte unchanged, next frame starts at operand A.
REQ-041 i_reset low in WAIT_OP and in SEND -> all outputs 0 asynchronously, no o_tx_start issued.
REQ-042 i_rx_done coincident with timeout terminal count -> byte accepted, no o_timeout.
